// File: rtl/pool_pkg.sv
// Shared types and helpers for the streaming pooling block.
// Holds the pooling mode encoding, accumulator sizing and the combine operator
// used by both the horizontal and the vertical reduction stages.
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  // Widest accumulator the combine helper handles; callers zero-extend into it
  // and keep only their own ACC low bits.
  localparam int ACC_MAX_W = 32;
  typedef logic [ACC_MAX_W-1:0] acc_max_t;

  // Averaging divides by POOL*POOL, which is a shift by 2*log2(POOL).
  function automatic int pool_shift(input int pool);
    return 2 * $clog2(pool);
  endfunction

  // A POOL x POOL sum of BITS-wide values needs 2*log2(POOL) extra bits.
  function automatic int acc_width(input int bits, input int pool);
    return bits + pool_shift(pool);
  endfunction

  // Max keeps the larger value, average accumulates a running sum.
  function automatic acc_max_t combine(input acc_max_t a, input acc_max_t b,
                                       input pool_mode_e m);
    if (m == POOL_MAX) begin
      return (a > b) ? a : b;
    end
    return a + b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding one partially reduced window column per pooled output column.
// Latency: synchronous write, combinational read.
// Backpressure: none; the parent only writes on accepted input beats.
module pool_line_buf #(
  parameter int N   = 16,
  parameter int CH  = 4,
  parameter int ACC = 10,
  parameter int IW  = 4
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [IW-1:0]           wr_idx,
  input  logic [CH-1:0][ACC-1:0]  wr_data,
  input  logic [IW-1:0]           rd_idx,
  output logic [CH-1:0][ACC-1:0]  rd_data
);

  // Storage spans the full index space so every index value addresses a real
  // entry; only the first N are ever written by the parent.
  localparam int DEPTH = 1 << IW;

  logic [CH-1:0][ACC-1:0] r_mem [DEPTH];

  // Entries are always overwritten on the first row of a window, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_idx];

  // N documents the number of live entries; it does not change the logic.
  localparam int N_USED = N;

endmodule

// File: rtl/pool_stream.sv
// Streaming POOL x POOL / stride-POOL max or average pooling over a DIM x DIM raster map.
// Latency: one cycle from the last contributing input beat to out_valid.
// Backpressure: in_ready drops while a pooled output is held unaccepted; no skid buffer.
module pool_stream
  import pool_pkg::*;
#(
  parameter int BITS = 8,
  parameter int DIM  = 32,
  parameter int CH   = 4,
  parameter int POOL = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*BITS-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*BITS-1:0]   out_data,
  output logic                 out_last,
  output logic                 frame_busy
);

  localparam int ACC   = acc_width(BITS, POOL);
  localparam int SHIFT = pool_shift(POOL);
  localparam int PW    = $clog2(POOL);
  localparam int CW    = $clog2(DIM);
  localparam int NW    = DIM / POOL;
  localparam int IW    = (NW > 1) ? $clog2(NW) : 1;

  // Position and frame state
  logic [CW-1:0]          r_col;
  logic [CW-1:0]          r_row;
  pool_mode_e             r_mode;
  logic [CH-1:0][ACC-1:0] r_h_acc;
  logic                   r_busy;

  // Output register
  logic                   r_out_valid;
  logic                   r_out_last;
  logic [CH*BITS-1:0]     r_out_data;

  // Beat decode
  logic                   w_fire;
  logic                   w_first;
  logic                   w_last_pix;
  logic [PW-1:0]          w_col_sub;
  logic [PW-1:0]          w_row_sub;
  logic                   w_win_end;
  logic                   w_row_end;
  logic                   w_out_load;
  logic                   w_out_take;
  pool_mode_e             w_mode;
  logic [IW-1:0]          w_idx;

  // Datapath
  logic [CH-1:0][ACC-1:0] w_pix;
  logic [CH-1:0][ACC-1:0] w_h_new;
  logic [CH-1:0][ACC-1:0] w_v_new;
  logic [CH-1:0][ACC-1:0] w_lb_rd;
  acc_max_t [CH-1:0]      w_h_cmb;
  acc_max_t [CH-1:0]      w_v_cmb;
  logic [CH*BITS-1:0]     w_res;
  logic                   w_unused;

  assign in_ready   = ~(r_out_valid & ~out_ready);
  assign w_fire     = in_valid & in_ready;
  assign w_out_take = r_out_valid & out_ready;

  assign w_first    = (r_col == '0) && (r_row == '0);
  assign w_last_pix = (r_col == CW'(DIM - 1)) && (r_row == CW'(DIM - 1));
  assign w_col_sub  = r_col[PW-1:0];
  assign w_row_sub  = r_row[PW-1:0];
  assign w_win_end  = (w_col_sub == PW'(POOL - 1));
  assign w_row_end  = (w_row_sub == PW'(POOL - 1));
  assign w_out_load = w_fire & w_win_end & w_row_end;
  assign w_idx      = IW'(r_col >> PW);

  // The mode register only loads at the end of the first beat, so that beat
  // must already use the incoming mode to pool consistently with the rest.
  assign w_mode = w_first ? pool_mode_e'(mode) : r_mode;

  // Horizontal and vertical reduction, then final scaling per channel
  always_comb begin
    w_pix   = '0;
    w_h_cmb = '0;
    w_h_new = '0;
    w_v_cmb = '0;
    w_v_new = '0;
    w_res   = '0;
    for (int c = 0; c < CH; c++) begin
      w_pix[c]   = ACC'(in_data[c*BITS +: BITS]);
      w_h_cmb[c] = combine(acc_max_t'(r_h_acc[c]), acc_max_t'(w_pix[c]), w_mode);
      w_h_new[c] = (w_col_sub == '0) ? w_pix[c] : w_h_cmb[c][ACC-1:0];
      w_v_cmb[c] = combine(acc_max_t'(w_lb_rd[c]), acc_max_t'(w_h_new[c]), w_mode);
      w_v_new[c] = (w_row_sub == '0) ? w_h_new[c] : w_v_cmb[c][ACC-1:0];
      if (w_mode == POOL_MAX) begin
        w_res[c*BITS +: BITS] = w_v_new[c][BITS-1:0];
      end else begin
        w_res[c*BITS +: BITS] = BITS'(w_v_new[c] >> SHIFT);
      end
    end
  end

  // ACC is sized so the combine result never reaches the upper helper bits.
  assign w_unused = ^{w_h_cmb, w_v_cmb};

  pool_line_buf #(
    .N   (NW),
    .CH  (CH),
    .ACC (ACC),
    .IW  (IW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (w_fire & w_win_end),
    .wr_idx  (w_idx),
    .wr_data (w_v_new),
    .rd_idx  (w_idx),
    .rd_data (w_lb_rd)
  );

  // Raster counters, per-frame mode latch and horizontal accumulator advance on accepted beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_mode  <= POOL_MAX;
      r_h_acc <= '0;
    end else if (w_fire) begin
      r_h_acc <= w_h_new;
      if (w_first) begin
        r_mode <= pool_mode_e'(mode);
      end
      if (r_col == CW'(DIM - 1)) begin
        r_col <= '0;
        r_row <= (r_row == CW'(DIM - 1)) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Output register: a new result may reload in the same cycle the old one is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_out_load) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_last_pix;
      r_out_data  <= w_res;
    end else if (w_out_take) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  // Busy from the first accepted beat until the final output is taken; a new
  // frame starting in that same cycle keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
    end else if (w_fire && w_first) begin
      r_busy <= 1'b1;
    end else if (w_out_take && r_out_last) begin
      r_busy <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign out_data   = r_out_data;
  assign frame_busy = r_busy;

endmodule

// File: tb/tb_pool_stream.sv
// Directed bench for pool_stream: a POOL=2 single-channel instance and a
// POOL=4 two-channel instance, checked against hand-computed pooled values.
module tb_pool_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       p2_mode, p2_in_valid, p2_in_ready, p2_out_valid, p2_out_ready;
  logic       p2_out_last, p2_busy;
  logic [7:0] p2_in_data, p2_out_data;

  logic        p4_mode, p4_in_valid, p4_in_ready, p4_out_valid, p4_out_ready;
  logic        p4_out_last, p4_busy;
  logic [15:0] p4_in_data, p4_out_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]  q2_d[$];
  logic        q2_l[$];
  logic [15:0] q4_d[$];
  logic        q4_l[$];

  logic [7:0] seq [16];

  pool_stream #(.BITS(8), .DIM(4), .CH(1), .POOL(2)) u_p2 (
    .clk(clk), .rst_n(rst_n), .mode(p2_mode),
    .in_valid(p2_in_valid), .in_ready(p2_in_ready), .in_data(p2_in_data),
    .out_valid(p2_out_valid), .out_ready(p2_out_ready), .out_data(p2_out_data),
    .out_last(p2_out_last), .frame_busy(p2_busy)
  );

  pool_stream #(.BITS(8), .DIM(4), .CH(2), .POOL(4)) u_p4 (
    .clk(clk), .rst_n(rst_n), .mode(p4_mode),
    .in_valid(p4_in_valid), .in_ready(p4_in_ready), .in_data(p4_in_data),
    .out_valid(p4_out_valid), .out_ready(p4_out_ready), .out_data(p4_out_data),
    .out_last(p4_out_last), .frame_busy(p4_busy)
  );

  // Record every accepted output; inputs only change 1 time unit after posedge.
  always @(negedge clk) begin
    if (p2_out_valid && p2_out_ready) begin
      q2_d.push_back(p2_out_data);
      q2_l.push_back(p2_out_last);
    end
    if (p4_out_valid && p4_out_ready) begin
      q4_d.push_back(p4_out_data);
      q4_l.push_back(p4_out_last);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Called just after a posedge; returns just after the posedge that accepts the beat.
  task automatic p2_beat(input logic [7:0] d, input logic m);
    int n;
    n = 0;
    p2_in_valid = 1'b1;
    p2_in_data  = d;
    p2_mode     = m;
    @(negedge clk);
    while (!p2_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!p2_in_ready) begin
      checks++;
      errors++;
      $display("FAIL p2_beat_timeout: in_ready=%0b required 1", p2_in_ready);
    end
    @(posedge clk);
    #1;
    p2_in_valid = 1'b0;
  endtask

  task automatic p4_beat(input logic [15:0] d, input logic m);
    int n;
    n = 0;
    p4_in_valid = 1'b1;
    p4_in_data  = d;
    p4_mode     = m;
    @(negedge clk);
    while (!p4_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!p4_in_ready) begin
      checks++;
      errors++;
      $display("FAIL p4_beat_timeout: in_ready=%0b required 1", p4_in_ready);
    end
    @(posedge clk);
    #1;
    p4_in_valid = 1'b0;
  endtask

  task automatic p2_frame(input logic m0, input logic mr);
    for (int i = 0; i < 16; i++) p2_beat(seq[i], (i == 0) ? m0 : mr);
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    p2_mode = 1'b0; p2_in_valid = 1'b0; p2_in_data = '0; p2_out_ready = 1'b1;
    p4_mode = 1'b0; p4_in_valid = 1'b0; p4_in_data = '0; p4_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (p2_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", p2_out_valid); end
    checks++; if (p2_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", p2_in_ready); end
    checks++; if (p2_out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h want 00", p2_out_data); end
    checks++; if (p2_out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b want 0", p2_out_last); end
    checks++; if (p2_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", p2_busy); end
    checks++; if (p4_out_valid !== 1'b0 || p4_in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_p4: valid=%b ready=%b want 0/1", p4_out_valid, p4_in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_max();
    logic [7:0] exp [4];
    exp = '{8'd6, 8'd8, 8'd14, 8'd16};
    q2_d.delete(); q2_l.delete();
    p2_frame(1'b0, 1'b0);
    @(negedge clk);
    checks++; if (p2_out_valid !== 1'b1 || p2_out_last !== 1'b1 || p2_busy !== 1'b1) begin
      errors++; $display("FAIL max_final_state: valid=%b last=%b busy=%b want 1/1/1", p2_out_valid, p2_out_last, p2_busy);
    end
    drain();
    checks++; if (p2_busy !== 1'b0) begin errors++; $display("FAIL max_busy_clear: got %b want 0", p2_busy); end
    checks++; if (q2_d.size() != 4) begin errors++; $display("FAIL max_count: got %0d want 4", q2_d.size()); end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] got;
      logic       gl;
      got = (i < q2_d.size()) ? q2_d[i] : 8'hxx;
      gl  = (i < q2_l.size()) ? q2_l[i] : 1'bx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL max_data[%0d]: got %0d want %0d", i, got, exp[i]); end
      checks++; if (gl !== (i == 3)) begin errors++; $display("FAIL max_last[%0d]: got %b want %b", i, gl, (i == 3)); end
    end
  endtask

  task automatic test_avg();
    logic [7:0] exp [4];
    exp = '{8'd3, 8'd5, 8'd11, 8'd13};
    q2_d.delete(); q2_l.delete();
    p2_frame(1'b1, 1'b1);
    drain();
    checks++; if (q2_d.size() != 4) begin errors++; $display("FAIL avg_count: got %0d want 4", q2_d.size()); end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] got;
      logic       gl;
      got = (i < q2_d.size()) ? q2_d[i] : 8'hxx;
      gl  = (i < q2_l.size()) ? q2_l[i] : 1'bx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL avg_data[%0d]: got %0d want %0d", i, got, exp[i]); end
      checks++; if (gl !== (i == 3)) begin errors++; $display("FAIL avg_last[%0d]: got %b want %b", i, gl, (i == 3)); end
    end
  endtask

  // POOL=4 over a 4x4 map: one output per frame. ch0 is the low byte.
  task automatic test_pool4();
    q4_d.delete(); q4_l.delete();
    for (int i = 0; i < 16; i++) p4_beat({8'(i), 8'hFF}, 1'b1);
    drain();
    for (int i = 0; i < 16; i++) p4_beat({8'(i), (i == 5) ? 8'd200 : 8'd0}, 1'b0);
    drain();
    checks++; if (q4_d.size() != 2) begin errors++; $display("FAIL p4_count: got %0d want 2", q4_d.size()); end
    checks++; if (q4_d.size() < 1 || q4_d[0] !== 16'h07FF) begin
      errors++; $display("FAIL p4_avg_sat: got %h want 07ff", (q4_d.size() > 0) ? q4_d[0] : 16'hxxxx);
    end
    checks++; if (q4_d.size() < 2 || q4_d[1] !== 16'h0FC8) begin
      errors++; $display("FAIL p4_max: got %h want 0fc8", (q4_d.size() > 1) ? q4_d[1] : 16'hxxxx);
    end
    checks++; if (q4_l.size() < 2 || q4_l[0] !== 1'b1 || q4_l[1] !== 1'b1) begin
      errors++; $display("FAIL p4_last: got %0d entries want both last=1", q4_l.size());
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [4];
    exp = '{8'd6, 8'd8, 8'd14, 8'd16};
    q2_d.delete(); q2_l.delete();
    p2_out_ready = 1'b0;
    fork
      p2_frame(1'b0, 1'b0);
      begin : watch
        int n;
        n = 0;
        @(negedge clk);
        while (!p2_out_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        checks++; if (p2_out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b want 1", p2_out_valid); end
        checks++; if (p2_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_drop: got %b want 0", p2_in_ready); end
        checks++; if (p2_out_data !== 8'd6) begin errors++; $display("FAIL bp_first_data: got %0d want 6", p2_out_data); end
        checks++; if (p2_busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b want 1", p2_busy); end
        repeat (4) @(negedge clk);
        checks++; if (p2_out_data !== 8'd6 || p2_out_valid !== 1'b1 || p2_in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_hold: data=%0d valid=%b ready=%b want 6/1/0", p2_out_data, p2_out_valid, p2_in_ready);
        end
        @(posedge clk);
        #1;
        p2_out_ready = 1'b1;
      end
    join
    drain();
    checks++; if (q2_d.size() != 4) begin errors++; $display("FAIL bp_count: got %0d want 4", q2_d.size()); end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] got;
      got = (i < q2_d.size()) ? q2_d[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, got, exp[i]); end
    end
  endtask

  // Mode flips after the first beat (ignored), then a back-to-back average frame.
  task automatic test_mode_toggle();
    logic [7:0] exp [8];
    exp = '{8'd6, 8'd8, 8'd14, 8'd16, 8'd3, 8'd5, 8'd11, 8'd13};
    q2_d.delete(); q2_l.delete();
    p2_frame(1'b0, 1'b1);
    p2_frame(1'b1, 1'b1);
    drain();
    checks++; if (q2_d.size() != 8) begin errors++; $display("FAIL mode_count: got %0d want 8", q2_d.size()); end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] got;
      logic       gl;
      got = (i < q2_d.size()) ? q2_d[i] : 8'hxx;
      gl  = (i < q2_l.size()) ? q2_l[i] : 1'bx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL mode_data[%0d]: got %0d want %0d", i, got, exp[i]); end
      checks++; if (gl !== (i == 3 || i == 7)) begin errors++; $display("FAIL mode_last[%0d]: got %b want %b", i, gl, (i == 3 || i == 7)); end
    end
    checks++; if (p2_busy !== 1'b0) begin errors++; $display("FAIL mode_busy_clear: got %b want 0", p2_busy); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [4];
    exp = '{8'd6, 8'd8, 8'd14, 8'd16};
    q2_d.delete(); q2_l.delete();
    for (int i = 0; i < 5; i++) p2_beat(8'd200, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (p2_out_valid !== 1'b0 || p2_busy !== 1'b0) begin
      errors++; $display("FAIL midrst_state: valid=%b busy=%b want 0/0", p2_out_valid, p2_busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++; if (q2_d.size() != 0) begin errors++; $display("FAIL midrst_stale: got %0d outputs want 0", q2_d.size()); end
    p2_frame(1'b0, 1'b0);
    drain();
    checks++; if (q2_d.size() != 4) begin errors++; $display("FAIL midrst_count: got %0d want 4", q2_d.size()); end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] got;
      got = (i < q2_d.size()) ? q2_d[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL midrst_data[%0d]: got %0d want %0d", i, got, exp[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) seq[i] = 8'(i + 1);
    test_reset();
    test_max();
    test_avg();
    test_pool4();
    test_backpressure();
    test_mode_toggle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_stream.md
Name: pool_stream

Overview:
- Streaming, parametrised successor to the whole-frame maxpool block.
- Consumes a square feature map one pixel per beat in raster order, carrying CH channels in parallel.
- Emits the POOL x POOL, stride-POOL pooled map in raster order, in max or average mode.
- Sits between the conv output stream and the next layer's input buffer; valid/ready on both sides.

Parameters:
- BITS, 8, unsigned element width.
- DIM, 32, input rows = columns; must be a multiple of POOL.
- CH, 4, channels per beat.
- POOL, 2, window size = stride; legal values 2 or 4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = max, 1 = average; sampled on the first accepted beat of each frame.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  CH x BITS  one pixel, all channels.
- out_valid  out  1  pooled pixel valid.
- out_ready  in  1  downstream accept.
- out_data  out  CH x BITS  pooled pixel, all channels.
- out_last  out  1  high with the final pooled pixel of a frame.
- frame_busy  out  1  high from the first accepted beat until the final output is accepted.

Behaviour:
- Reset values: all outputs 0, except in_ready = 1. Counters, line buffer valid state and latched mode also clear.
- Counters:
  - col, row: 0..DIM-1.
  - Advance only on an accepted input beat.
  - col wraps to 0 and row increments at col = DIM-1.
  - row wraps to 0 at the end of the frame.
- Mode latch: mode_q is loaded on the accepted beat with col = 0 and row = 0. A mode change mid-frame is ignored.
- Accumulator: ACC = BITS + 2*log2(POOL) bits per channel.
  - Max mode: running max.
  - Average mode: running sum.
- Horizontal stage:
  - The first beat of each window column (col % POOL == 0) loads h_acc.
  - Later beats combine into h_acc.
- At col % POOL == POOL-1, the combined value goes to the line buffer entry col/POOL (DIM/POOL entries):
  - row % POOL == 0: overwrite the entry.
  - Otherwise: combine with the existing entry.
- Output:
  - On the write at row % POOL == POOL-1, the final combined value is loaded into the output register and out_valid is set on the next edge. Latency is 1 cycle from the last contributing beat.
  - Max result: low BITS of the max.
  - Average result: sum >> 2*log2(POOL). Truncating; no rounding.
- out_last: set with the output for col = DIM-1, row = DIM-1.
- Backpressure:
  - in_ready = !(out_valid && !out_ready). No skid buffer.
  - Input is stalled only while a pending output is blocked.
  - Input beats that do not produce an output are also stalled in that case, so the beat order stays simple.
- Simultaneous events: a new output loading while the old one is accepted in the same cycle is legal. The output register reloads and out_valid stays 1.
- out_valid clears on acceptance when no new output is loaded.
- Frame boundary: the next frame may start on the cycle after the last input beat. frame_busy stays high across back-to-back frames until the last out_last is accepted.
- Reset mid-frame: partial windows are discarded, counters return to 0, and any pending output is dropped.
- No overflow is possible by construction of ACC.

Decomposition:
- pool_pkg holds:
  - mode enum: POOL_MAX, POOL_AVG.
  - function acc_width(BITS, POOL).
  - function clog2-based shift amount.
  - combine(a, b, mode) function, shared by the horizontal and vertical stages.
- One sub-module, pool_line_buf:
  - DIM/POOL x CH x ACC register array.
  - Synchronous write and combinational read by index.
  - No reset on storage; overwritten at row % POOL == 0.

Test Plan:
- Max, POOL=2, DIM=4, CH=1: ch0 rows 1 2 3 4 / 5 6 7 8 / 9 10 11 12 / 13 14 15 16 -> outputs 6, 8, 14, 16; out_last only on 16.
- Average, POOL=2, same frame -> outputs 3, 5, 11, 13 ((1+2+5+6)>>2 = 3, truncated).
- Saturation check, BITS=8, POOL=4, DIM=4, average, all 255 -> single output 255, no wrap. Max with one 200 among zeros -> 200.
- Backpressure: hold out_ready = 0 after the first output -> in_ready drops the next cycle, out_data holds 6. Release -> remaining outputs are unchanged and in order.
- Mode toggled mid-frame from 0 to 1 -> whole frame pooled as max. Next frame with mode = 1 -> average.
- Assert rst_n = 0 after 5 beats, then send a full fresh frame -> outputs match the golden model. No stale output, and out_valid is 0 during reset.
